// File: rtl/bcd_display.sv
// Four-digit multiplexed seven-segment display driver.
// A 12-bit binary value is converted to BCD by a sequential double-dabble
// engine (12 cycles). The committed digits are then scanned one at a time
// onto a shared segment bus. An optional leading-zero blanking mode is
// available, and a blank input suppresses all digit enables.
// seg and an come straight from flops, so they only change on clock edges
// and never glitch while a new result is being committed.

module bcd_display #(
   parameter int REFRESH_DIV = 1000,
   parameter bit LZ_BLANK    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] value,
   input  logic        load,
   input  logic        blank,
   output logic        busy,
   output logic        done,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

   state_t      state_q;
   logic [3:0]  iter_q;
   logic [27:0] shift_q;
   logic [27:0] shift_d;
   logic [27:0] shiftAdj;
   logic [15:0] digits_q;
   logic [15:0] digits_d;
   logic        done_q;

   logic [15:0] refCnt_q;
   logic [15:0] refCnt_d;
   logic        refWrap;
   logic [1:0]  idx_q;
   logic [1:0]  idx_d;
   logic [3:0]  nibble;
   logic        upperZero;
   logic [6:0]  seg_q;
   logic [6:0]  seg_d;
   logic [3:0]  an_q;
   logic [3:0]  an_d;

   function automatic logic [6:0] decodeDigit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // One double-dabble step: correct every BCD nibble that is 5 or more, then shift left.
   always_comb begin
      shiftAdj = shift_q;
      for (int k = 0; k < 4; k++) begin
         if (shiftAdj[12 + 4*k +: 4] >= 4'd5) begin
            shiftAdj[12 + 4*k +: 4] = shiftAdj[12 + 4*k +: 4] + 4'd3;
         end
      end
      shift_d = shiftAdj << 1;
   end

   // The digit register takes the converted BCD only on the final iteration edge.
   always_comb begin
      digits_d = digits_q;
      if (state_q == SHIFT && iter_q == 4'd11) begin
         digits_d = shift_d[27:12];
      end
   end

   // Conversion FSM: capture on load, iterate twelve times, commit, pulse done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         iter_q   <= 4'd0;
         shift_q  <= 28'd0;
         digits_q <= 16'd0;
         done_q   <= 1'b0;
      end else begin
         digits_q <= digits_d;
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (load) begin
                  shift_q <= {16'd0, value};
                  iter_q  <= 4'd0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               shift_q <= shift_d;
               iter_q  <= iter_q + 4'd1;
               if (iter_q == 4'd11) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Free-running scan timer; the digit index steps each time it wraps.
   always_comb begin
      refWrap  = (refCnt_q == REFRESH_LAST);
      refCnt_d = refWrap ? 16'd0 : refCnt_q + 16'd1;
      idx_d    = refWrap ? idx_q + 2'd1 : idx_q;
   end

   // Pick the digit that will be shown next and decide whether it is a leading zero.
   always_comb begin
      nibble    = 4'd0;
      upperZero = 1'b0;
      case (idx_d)
         2'd0: begin
            nibble    = digits_d[3:0];
            upperZero = 1'b0;
         end
         2'd1: begin
            nibble    = digits_d[7:4];
            upperZero = (digits_d[15:4] == 12'd0);
         end
         2'd2: begin
            nibble    = digits_d[11:8];
            upperZero = (digits_d[15:8] == 8'd0);
         end
         default: begin
            nibble    = digits_d[15:12];
            upperZero = (digits_d[15:12] == 4'd0);
         end
      endcase
      seg_d = (LZ_BLANK && upperZero) ? 7'd0 : decodeDigit(nibble);
      an_d  = blank ? 4'b0000 : (4'b0001 << idx_d);
   end

   // Scan state and registered display outputs, computed from next-state values so they line up with the digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         refCnt_q <= 16'd0;
         idx_q    <= 2'd0;
         seg_q    <= 7'b0111111;
         an_q     <= blank ? 4'b0000 : 4'b0001;
      end else begin
         refCnt_q <= refCnt_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign seg  = seg_q;
   assign an   = an_q;

endmodule
